axi_mem_responder: RTL
======================

// Module: axi_mem_responder
// PURPOSE
//  AXI4 slave (responder) backed by an on-chip word-addressed memory.
//  - Accepts the flat m_axi_* bus driven by the initiator side of the design.
//  - Serves INCR/FIXED bursts with independent read and write engines.
//  - Used as the memory endpoint for standalone and sim runs of the merge kernels.
// PARAMETERS
//  AXI_ADDR_WIDTH  64    byte address width
//  AXI_DATA_WIDTH  512   data width; beat = AXI_DATA_WIDTH/8 bytes (power of 2)
//  AXI_ID_WIDTH    4     ID width; bid/rid echo the accepted awid/arid
//  MEM_DEPTH       1024  memory words (one beat each)
// PORTS
//  clk            in   1    single clock
//  rst            in   1    synchronous, active-high reset
//  s_axi_aw*      in/out    awvalid,awready,awaddr[AW],awburst[2],awlen[8],awsize[3],awid[ID]
//  s_axi_w*       in/out    wvalid,wready,wdata[DW],wstrb[DW/8],wlast
//  s_axi_b*       in/out    bvalid,bready,bresp[2],bid[ID]
//  s_axi_ar*      in/out    arvalid,arready,araddr[AW],arburst[2],arlen[8],arsize[3],arid[ID]
//  s_axi_r*       in/out    rvalid,rready,rdata[DW],rlast,rid[ID],rresp[2]
//  (optional) stat_wr_bursts out 32, stat_rd_bursts out 32, stat_err out 32
// BEHAVIOUR
//  Reset: awready=arready=1, wready=bvalid=rvalid=rlast=0, bresp=rresp=0, bid=rid=0, rdata=0.
//    Reset mid-burst aborts both FSMs to IDLE; memory contents are kept.
//  Word index = addr[AW-1:log2(DW/8)]; low address bits are ignored.
//  Error check at AW/AR handshake: SLVERR(2'b10) when any of:
//    - size != log2(DW/8);
//    - burst == WRAP or 2'b11;
//    - any beat index >= MEM_DEPTH.
//  Error bursts still run their full beat count:
//    - writes are suppressed;
//    - rdata = 0.
//  INCR: index +1 per beat. FIXED: index constant.
//  Write FSM:
//    - W_IDLE (awready=1): on handshake latch addr/len/id/err -> W_DATA.
//    - W_DATA (wready=1): per wvalid beat, write bytes enabled by wstrb in the same
//      cycle; beat counter runs 0..awlen. Final beat (count==awlen) -> W_RESP.
//    - wlast not matching (count==awlen) on any beat -> sticky SLVERR; burst end is
//      set by the count, not by wlast.
//    - W_RESP (bvalid=1, bid=awid, bresp=OKAY/SLVERR): hold until bready -> W_IDLE.
//    - First write beat is 1 cycle after AW; bvalid 1 cycle after the last beat.
//  Read FSM:
//    - R_IDLE (arready=1): on handshake -> R_FETCH.
//    - R_FETCH: rdata <= mem[idx] -> R_DATA. Registered read; first rvalid 2 cycles
//      after AR handshake.
//    - R_DATA (rvalid=1, rid, rresp, rlast = count==arlen): outputs stable while
//      rready=0.
//    - On handshake: not last -> rdata <= mem[next idx] in the same cycle (1 beat/clk);
//      last -> R_IDLE.
//  Same-cycle read fetch and write to the same word: the read returns the OLD data.
//  Read and write engines run fully concurrently; one outstanding burst per direction.
//  awlen/arlen = 255 (256 beats) is supported; counters are 9 bits wide.
// CONFIGURATION
//  `AXI_MEM_RESP_STATS_EN` defined: stat_* counters present. They increment on B
//    handshake, on the last R handshake, and on each SLVERR response; they wrap at 2^32
//    and clear on rst.
//  Undefined: the stat_* ports are absent and add no logic.
// STRUCTURE
//  Shared package axi_mem_pkg:
//    - typedefs: burst_t (FIXED/INCR/WRAP), resp_t (OKAY/SLVERR), wr_state_t, rd_state_t;
//    - localparam BEAT_BYTES.
//  Sub-module axi_mem_bram: 1 write port with byte enables, 1 registered read port;
//    infers block RAM.
// TESTING
//  1. Write INCR awaddr=0x40,len=3,full wstrb -> bresp=OKAY, bid echoed; read back the same
//     burst -> 4 beats, rlast on beat 4, data matches.
//  2. wstrb=0x...0F on word 5 after writing all-ones -> readback keeps upper bytes at 1s and
//     holds the new low 4 bytes.
//  3. araddr=(MEM_DEPTH-1)*64,len=1 -> 2 beats, both rresp=SLVERR, rdata=0.
//  4. rready toggling 1/0 across a 16-beat read -> no beat dropped or duplicated, rdata
//     stable while stalled.
//  5. wlast asserted on beat 2 of a len=3 burst -> 4 beats accepted, bresp=SLVERR.
//  6. rst asserted mid-read burst -> next cycle rvalid=0, arready=1; memory data intact.

Source files
------------

// File: rtl/axi_mem_pkg.sv
// Shared types for the AXI memory responder: burst/response encodings and engine states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_mem_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } rd_state_t;

  // Bytes per beat at the default 512-bit data width.
  localparam int BEAT_BYTES = 64;

endpackage

// File: rtl/axi_mem_bram.sv
// Word memory with one byte-enabled write port and one registered read port.
// Latency: write lands at the clock edge; read data valid the cycle after re.
// Backpressure: none; read output holds its value while re is low.
module axi_mem_bram #(
  parameter int DW    = 512,
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [DW/8-1:0]  wbe,
  input  logic [DW-1:0]    wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [DW-1:0]    rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Byte-lane writes; lanes with a clear enable keep their contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Registered read; a same-cycle write to the same word is not forwarded (old data).
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by on-chip memory; independent INCR/FIXED read and write engines.
// Latency: first W beat 1 cycle after AW, B 1 cycle after last W, first R 2 cycles after AR.
// Backpressure: R outputs held while rready=0; B held until bready. AXI_MEM_RESP_STATS_EN adds stat_* counters.
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = BEAT_BYTES * 8,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_DEPTH      = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [1:0]                  s_axi_awburst,
  input  logic [7:0]                  s_axi_awlen,
  input  logic [2:0]                  s_axi_awsize,
  input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                        s_axi_wlast,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  output logic [1:0]                  s_axi_bresp,
  output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [1:0]                  s_axi_arburst,
  input  logic [7:0]                  s_axi_arlen,
  input  logic [2:0]                  s_axi_arsize,
  input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                        s_axi_rlast,
  output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
  output logic [1:0]                  s_axi_rresp
`ifdef AXI_MEM_RESP_STATS_EN
  ,
  output logic [31:0]                 stat_wr_bursts,
  output logic [31:0]                 stat_rd_bursts,
  output logic [31:0]                 stat_err
`endif
);

  localparam int OFF   = $clog2(AXI_DATA_WIDTH / 8);
  localparam int WW    = AXI_ADDR_WIDTH - OFF;
  localparam int IDX_W = $clog2(MEM_DEPTH);

  // Decode-time error: bad size, WRAP/reserved burst, or any beat past the end of memory.
  // The word index carries one spare bit so first+len can never overflow.
  function automatic logic burst_err(input logic [WW-1:0] word, input logic [1:0] burst,
                                     input logic [7:0] len, input logic [2:0] size);
    logic [WW:0] last;
    last = {1'b0, word} + ((burst == BURST_INCR) ? {{(WW-7){1'b0}}, len} : '0);
    return (size != 3'(OFF)) || (burst == BURST_WRAP) || (burst == 2'b11) ||
           (last >= (WW+1)'(MEM_DEPTH));
  endfunction

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi_awaddr[OFF-1:0], s_axi_araddr[OFF-1:0]};

  // ---------------- write engine ----------------
  wr_state_t        w_state;
  logic [IDX_W-1:0] w_idx;
  logic [7:0]       w_len;
  logic [8:0]       w_cnt;
  logic             w_fixed, w_addr_err, w_last_err;
  logic             w_final, w_last_bad;

  assign w_final    = (w_cnt == {1'b0, w_len});
  assign w_last_bad = (s_axi_wlast != w_final);

  // Write FSM: latch AW, accept beats until the counter reaches awlen, then hold B.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_bid     <= '0;
      w_idx         <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_fixed       <= 1'b0;
      w_addr_err    <= 1'b0;
      w_last_err    <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (s_axi_awvalid) begin
          w_idx         <= s_axi_awaddr[OFF +: IDX_W];
          w_len         <= s_axi_awlen;
          w_fixed       <= (s_axi_awburst == BURST_FIXED);
          w_addr_err    <= burst_err(s_axi_awaddr[AXI_ADDR_WIDTH-1:OFF], s_axi_awburst,
                                     s_axi_awlen, s_axi_awsize);
          w_last_err    <= 1'b0;
          w_cnt         <= '0;
          s_axi_bid     <= s_axi_awid;
          s_axi_awready <= 1'b0;
          s_axi_wready  <= 1'b1;
          w_state       <= W_DATA;
        end
        W_DATA: if (s_axi_wvalid) begin
          if (w_last_bad) w_last_err <= 1'b1;
          if (!w_fixed) w_idx <= w_idx + IDX_W'(1);
          w_cnt <= w_cnt + 9'd1;
          if (w_final) begin
            s_axi_wready <= 1'b0;
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= (w_addr_err || w_last_err || w_last_bad) ? RESP_SLVERR : RESP_OKAY;
            w_state      <= W_RESP;
          end
        end
        W_RESP: if (s_axi_bready) begin
          s_axi_bvalid  <= 1'b0;
          s_axi_awready <= 1'b1;
          w_state       <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read engine ----------------
  rd_state_t           r_state;
  logic [IDX_W-1:0]    r_idx, r_nidx, rd_addr;
  logic [7:0]          r_len;
  logic [8:0]          r_cnt;
  logic                r_fixed, r_err, rd_en;
  logic [AXI_DATA_WIDTH-1:0] rd_q;

  assign r_nidx  = r_fixed ? r_idx : r_idx + IDX_W'(1);
  // Fetch on entry to the burst and again on every non-last beat handshake.
  assign rd_en   = (r_state == R_FETCH) ||
                   ((r_state == R_DATA) && s_axi_rready && !s_axi_rlast);
  assign rd_addr = (r_state == R_FETCH) ? r_idx : r_nidx;
  assign s_axi_rdata = (s_axi_rvalid && !r_err) ? rd_q : '0;

  // Read FSM: one fetch cycle, then one beat per clock while rready is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rid     <= '0;
      r_idx         <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_fixed       <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (s_axi_arvalid) begin
          r_idx         <= s_axi_araddr[OFF +: IDX_W];
          r_len         <= s_axi_arlen;
          r_fixed       <= (s_axi_arburst == BURST_FIXED);
          r_err         <= burst_err(s_axi_araddr[AXI_ADDR_WIDTH-1:OFF], s_axi_arburst,
                                     s_axi_arlen, s_axi_arsize);
          r_cnt         <= '0;
          s_axi_rid     <= s_axi_arid;
          s_axi_arready <= 1'b0;
          r_state       <= R_FETCH;
        end
        R_FETCH: begin
          s_axi_rvalid <= 1'b1;
          s_axi_rresp  <= r_err ? RESP_SLVERR : RESP_OKAY;
          s_axi_rlast  <= (r_len == 8'd0);
          r_state      <= R_DATA;
        end
        R_DATA: if (s_axi_rready) begin
          if (s_axi_rlast) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_arready <= 1'b1;
            r_state       <= R_IDLE;
          end else begin
            r_idx       <= r_nidx;
            r_cnt       <= r_cnt + 9'd1;
            s_axi_rlast <= ((r_cnt + 9'd1) == {1'b0, r_len});
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  axi_mem_bram #(
    .DW    (AXI_DATA_WIDTH),
    .DEPTH (MEM_DEPTH),
    .IDX_W (IDX_W)
  ) u_bram (
    .clk   (clk),
    .we    ((w_state == W_DATA) && s_axi_wvalid && !w_addr_err),
    .waddr (w_idx),
    .wbe   (s_axi_wstrb),
    .wdata (s_axi_wdata),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_q)
  );

`ifdef AXI_MEM_RESP_STATS_EN
  // Burst and error counters; free-running, wrap at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_wr_bursts <= '0;
      stat_rd_bursts <= '0;
      stat_err       <= '0;
    end else begin
      if (s_axi_bvalid && s_axi_bready) stat_wr_bursts <= stat_wr_bursts + 32'd1;
      if (s_axi_rvalid && s_axi_rready && s_axi_rlast) stat_rd_bursts <= stat_rd_bursts + 32'd1;
      stat_err <= stat_err
                + 32'(s_axi_bvalid && s_axi_bready && (s_axi_bresp == RESP_SLVERR))
                + 32'(s_axi_rvalid && s_axi_rready && s_axi_rlast && (s_axi_rresp == RESP_SLVERR));
    end
  end
`endif

endmodule
